// File: rtl/ram_pkg.sv
// Shared types for the occupancy grid RAM and its controller.
// Grid geometry and cell word width live here so the datapath and the FSM agree.
package ram_pkg;

  localparam int WORD_SIZE   = 8;
  localparam int GRID_WIDTH  = 16;
  localparam int GRID_HEIGHT = 16;
  localparam int X_BITS      = $clog2(GRID_WIDTH);
  localparam int Y_BITS      = $clog2(GRID_HEIGHT);

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [X_BITS-1:0]    width_index_t;
  typedef logic [Y_BITS-1:0]    height_index_t;

  typedef enum logic [2:0] {
    IDLE,
    CLR_INIT,
    CLR_RUN,
    UPD_READ,
    UPD_WRITE
  } occ_ctrl_state_t;

  // True when applying the update would wrap the cell counter.
  function automatic logic is_saturated(input word_t value, input logic free);
    return free ? (value == '0) : (value == '1);
  endfunction

endpackage

// File: rtl/occupancy_ctrl.sv
// Control FSM for the occupancy grid: whole-grid clear sequencing and
// read-modify-write cell updates driven into the occupancy datapath.
module occupancy_ctrl
  import ram_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter bit SATURATE     = 1'b1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear_req,
  input  logic          upd_valid,
  output logic          upd_ready,
  input  width_index_t  upd_x,
  input  height_index_t upd_y,
  input  logic          upd_free,
  input  word_t         data_in,
  input  logic          count_done,
  output logic          zero_cell,
  output logic          write_enable,
  output logic          cell_is_free,
  output logic          reset_counter,
  output logic          enable_counter,
  output width_index_t  x,
  output height_index_t y,
  output logic          busy,
  output logic          clear_done
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LATENCY - 1);

  occ_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0] rd_cnt_q;
  width_index_t     x_q;
  height_index_t    y_q;
  logic             free_q;
  logic             pend_q;
  logic             clear_done_q;

  logic clear_go;
  logic accept;
  logic sat_block;

  assign clear_go  = clear_req | pend_q;
  // Gated by reset_n so the handshake stays quiet while the block is held in reset.
  assign upd_ready = reset_n & (state_q == IDLE) & ~clear_go;
  assign accept    = upd_valid & upd_ready;
  assign sat_block = SATURATE && is_saturated(data_in, free_q);

  always_comb begin
    // NOTE: every combinationally driven signal gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (clear_go)       state_d = CLR_INIT;
        else if (upd_valid) state_d = UPD_READ;
      end
      CLR_INIT:  state_d = CLR_RUN;
      CLR_RUN:   if (count_done) state_d = IDLE;
      UPD_READ:  if (rd_cnt_q == RD_LAST) state_d = UPD_WRITE;
      UPD_WRITE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // The saturation guard has to look at the live read data, so write_enable
  // is the one control output with a data_in term; all others decode state only.
  always_comb begin
    zero_cell      = 1'b0;
    write_enable   = 1'b0;
    cell_is_free   = 1'b0;
    reset_counter  = 1'b0;
    enable_counter = 1'b0;
    unique case (state_q)
      CLR_INIT: reset_counter = 1'b1;
      CLR_RUN: begin
        zero_cell      = 1'b1;
        write_enable   = 1'b1;
        enable_counter = 1'b1;
      end
      UPD_WRITE: begin
        cell_is_free = free_q;
        write_enable = ~sat_block;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign clear_done = clear_done_q;
  assign x          = x_q;
  assign y          = y_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rd_cnt_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      free_q       <= 1'b0;
      pend_q       <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q      <= state_d;
      clear_done_q <= (state_q == CLR_RUN) && count_done;

      if (accept) begin
        x_q    <= upd_x;
        y_q    <= upd_y;
        free_q <= upd_free;
      end

      if (state_q == UPD_READ) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      else                     rd_cnt_q <= '0;

      // A request seen while busy is remembered; finishing a clear satisfies it.
      if ((state_q == CLR_RUN) && count_done) pend_q <= 1'b0;
      else if (clear_req && (state_q != IDLE)) pend_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_occupancy_ctrl.sv
// Directed, table-driven bench for occupancy_ctrl across latency and saturation variants.
module tb_occupancy_ctrl;
  import ram_pkg::*;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          rst3_n = 1'b0;
  logic          clear_req = 1'b0;
  logic          upd_valid = 1'b0;
  width_index_t  upd_x = '0;
  height_index_t upd_y = '0;
  logic          upd_free = 1'b0;
  word_t         data_in = '0;
  logic          count_done = 1'b0;

  logic upd_ready1, zero_cell1, write_enable1, cell_is_free1, reset_counter1, enable_counter1, busy1, clear_done1;
  logic upd_ready0, zero_cell0, write_enable0, cell_is_free0, reset_counter0, enable_counter0, busy0, clear_done0;
  logic upd_ready3, zero_cell3, write_enable3, cell_is_free3, reset_counter3, enable_counter3, busy3, clear_done3;
  width_index_t  x1, x0, x3;
  height_index_t y1, y0, y3;
  logic [7:0] ctrl1, ctrl0, ctrl3;

  // Bit order: {upd_ready, busy, clear_done, zero_cell, write_enable, cell_is_free, reset_counter, enable_counter}
  assign ctrl1 = {upd_ready1, busy1, clear_done1, zero_cell1, write_enable1, cell_is_free1, reset_counter1, enable_counter1};
  assign ctrl0 = {upd_ready0, busy0, clear_done0, zero_cell0, write_enable0, cell_is_free0, reset_counter0, enable_counter0};
  assign ctrl3 = {upd_ready3, busy3, clear_done3, zero_cell3, write_enable3, cell_is_free3, reset_counter3, enable_counter3};

  occupancy_ctrl #(.READ_LATENCY(1), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .upd_valid(upd_valid),
    .upd_ready(upd_ready1), .upd_x(upd_x), .upd_y(upd_y), .upd_free(upd_free),
    .data_in(data_in), .count_done(count_done), .zero_cell(zero_cell1),
    .write_enable(write_enable1), .cell_is_free(cell_is_free1), .reset_counter(reset_counter1),
    .enable_counter(enable_counter1), .x(x1), .y(y1), .busy(busy1), .clear_done(clear_done1)
  );

  occupancy_ctrl #(.READ_LATENCY(1), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .upd_valid(upd_valid),
    .upd_ready(upd_ready0), .upd_x(upd_x), .upd_y(upd_y), .upd_free(upd_free),
    .data_in(data_in), .count_done(count_done), .zero_cell(zero_cell0),
    .write_enable(write_enable0), .cell_is_free(cell_is_free0), .reset_counter(reset_counter0),
    .enable_counter(enable_counter0), .x(x0), .y(y0), .busy(busy0), .clear_done(clear_done0)
  );

  occupancy_ctrl #(.READ_LATENCY(3), .SATURATE(1'b1)) dut_lat3 (
    .clock(clock), .reset_n(rst3_n), .clear_req(clear_req), .upd_valid(upd_valid),
    .upd_ready(upd_ready3), .upd_x(upd_x), .upd_y(upd_y), .upd_free(upd_free),
    .data_in(data_in), .count_done(count_done), .zero_cell(zero_cell3),
    .write_enable(write_enable3), .cell_is_free(cell_is_free3), .reset_counter(reset_counter3),
    .enable_counter(enable_counter3), .x(x3), .y(y3), .busy(busy3), .clear_done(clear_done3)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          clr;
    logic          vld;
    width_index_t  ux;
    height_index_t uy;
    logic          fr;
    word_t         din;
    logic          cd;
    logic [7:0]    ctrl;
    width_index_t  ex;
    height_index_t ey;
    logic          sat_diff;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic clr, input logic vld, input width_index_t ux,
                              input height_index_t uy, input logic fr, input word_t din,
                              input logic cd, input logic [7:0] ctrl, input width_index_t ex,
                              input height_index_t ey, input logic sat_diff);
    vec_t v;
    v.clr = clr; v.vld = vld; v.ux = ux; v.uy = uy; v.fr = fr; v.din = din; v.cd = cd;
    v.ctrl = ctrl; v.ex = ex; v.ey = ey; v.sat_diff = sat_diff;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic lat3_update(input width_index_t ux, input height_index_t uy, input logic fr);
    @(posedge clock); #1;
    upd_valid = 1'b1; upd_x = ux; upd_y = uy; upd_free = fr; data_in = 8'h20;
    @(negedge clock);
    check("lat3 ready in idle", upd_ready3, 1'b1);
    @(posedge clock); #1;
    upd_valid = 1'b0; upd_x = 4'hA; upd_y = 4'hB;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("lat3 busy k=%0d", k), busy3, 1'b1);
      check($sformatf("lat3 we k=%0d", k), write_enable3, (k == 3));
      check($sformatf("lat3 addr k=%0d", k), {x3, y3}, {ux, uy});
    end
  endtask

  initial begin
    vecs.push_back(mk(0,0, 0, 0,0,8'h00,0,8'b1000_0000,0,0,0)); // 0 idle after reset
    vecs.push_back(mk(1,0, 0, 0,0,8'h00,0,8'b0000_0000,0,0,0)); // 1 clear pulse
    vecs.push_back(mk(0,0, 0, 0,0,8'h00,0,8'b0100_0010,0,0,0)); // 2 CLR_INIT
    vecs.push_back(mk(0,0, 0, 0,0,8'h00,0,8'b0101_1001,0,0,0)); // 3 CLR_RUN
    vecs.push_back(mk(0,0, 0, 0,0,8'h00,0,8'b0101_1001,0,0,0)); // 4
    vecs.push_back(mk(0,0, 0, 0,0,8'h00,1,8'b0101_1001,0,0,0)); // 5 last cell
    vecs.push_back(mk(0,0, 0, 0,0,8'h00,0,8'b1010_0000,0,0,0)); // 6 clear_done
    vecs.push_back(mk(0,0, 0, 0,0,8'h00,0,8'b1000_0000,0,0,0)); // 7
    vecs.push_back(mk(0,1, 5, 3,0,8'h07,0,8'b1000_0000,0,0,0)); // 8 accept 5,3
    vecs.push_back(mk(0,0,10,11,0,8'h07,0,8'b0100_0000,5,3,0)); // 9 read
    vecs.push_back(mk(0,0,10,11,0,8'h07,0,8'b0100_1000,5,3,0)); // 10 write
    vecs.push_back(mk(0,0,10,11,0,8'h07,0,8'b1000_0000,5,3,0)); // 11
    vecs.push_back(mk(0,1, 2, 1,0,8'hFF,0,8'b1000_0000,5,3,0)); // 12 inc at max
    vecs.push_back(mk(0,0,10,11,0,8'hFF,0,8'b0100_0000,2,1,0)); // 13
    vecs.push_back(mk(0,0,10,11,0,8'hFF,0,8'b0100_0000,2,1,1)); // 14 suppressed
    vecs.push_back(mk(0,1, 4, 6,1,8'h00,0,8'b1000_0000,2,1,0)); // 15 dec at zero
    vecs.push_back(mk(0,0,10,11,1,8'h00,0,8'b0100_0000,4,6,0)); // 16
    vecs.push_back(mk(0,0,10,11,1,8'h00,0,8'b0100_0100,4,6,1)); // 17 suppressed
    vecs.push_back(mk(0,1, 1, 1,1,8'h10,0,8'b1000_0000,4,6,0)); // 18 normal free
    vecs.push_back(mk(0,0,10,11,1,8'h10,0,8'b0100_0000,1,1,0)); // 19
    vecs.push_back(mk(0,0,10,11,1,8'h10,0,8'b0100_1100,1,1,0)); // 20
    vecs.push_back(mk(0,0,10,11,0,8'h00,0,8'b1000_0000,1,1,0)); // 21
    vecs.push_back(mk(1,1, 7, 7,0,8'h03,0,8'b0000_0000,1,1,0)); // 22 clear beats update
    vecs.push_back(mk(0,1, 7, 7,0,8'h03,0,8'b0100_0010,1,1,0)); // 23
    vecs.push_back(mk(0,1, 7, 7,0,8'h03,1,8'b0101_1001,1,1,0)); // 24
    vecs.push_back(mk(0,1, 7, 7,0,8'h03,0,8'b1010_0000,1,1,0)); // 25 accepted now
    vecs.push_back(mk(0,0,10,11,0,8'h03,0,8'b0100_0000,7,7,0)); // 26
    vecs.push_back(mk(0,0,10,11,0,8'h03,0,8'b0100_1000,7,7,0)); // 27
    vecs.push_back(mk(0,0,10,11,0,8'h03,0,8'b1000_0000,7,7,0)); // 28
    vecs.push_back(mk(0,1, 3, 2,1,8'h09,0,8'b1000_0000,7,7,0)); // 29 accept 3,2
    vecs.push_back(mk(1,0,10,11,1,8'h09,0,8'b0100_0000,3,2,0)); // 30 clear during read
    vecs.push_back(mk(0,0,10,11,1,8'h09,0,8'b0100_1100,3,2,0)); // 31 write completes
    vecs.push_back(mk(0,0,10,11,0,8'h00,0,8'b0000_0000,3,2,0)); // 32 pending clear
    vecs.push_back(mk(0,0,10,11,0,8'h00,0,8'b0100_0010,3,2,0)); // 33
    vecs.push_back(mk(0,0,10,11,0,8'h00,1,8'b0101_1001,3,2,0)); // 34
    vecs.push_back(mk(0,0,10,11,0,8'h00,0,8'b1010_0000,3,2,0)); // 35
    vecs.push_back(mk(0,0,10,11,0,8'h00,0,8'b1000_0000,3,2,0)); // 36

    repeat (2) @(negedge clock);
    check("reset ctrl sat", ctrl1, 8'h00);
    check("reset ctrl lat3", ctrl3, 8'h00);
    check("reset addr", {x1, y1}, 8'h00);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      logic [7:0] exp_wrap;
      @(posedge clock); #1;
      clear_req = vecs[i].clr; upd_valid = vecs[i].vld; upd_x = vecs[i].ux; upd_y = vecs[i].uy;
      upd_free = vecs[i].fr; data_in = vecs[i].din; count_done = vecs[i].cd;
      @(negedge clock);
      exp_wrap = vecs[i].ctrl;
      if (vecs[i].sat_diff) exp_wrap[3] = 1'b1;
      check($sformatf("row%0d ctrl", i), ctrl1, vecs[i].ctrl);
      check($sformatf("row%0d x", i), x1, vecs[i].ex);
      check($sformatf("row%0d y", i), y1, vecs[i].ey);
      check($sformatf("row%0d ctrl nosat", i), ctrl0, exp_wrap);
    end

    // Reset asserted in the middle of a clear sweep.
    @(posedge clock); #1;
    clear_req = 1'b1; upd_valid = 1'b0; count_done = 1'b0;
    @(posedge clock); #1;
    clear_req = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("mid clear running", ctrl1, 8'b0101_1001);
    #1 reset_n = 1'b0;
    #1;
    check("async reset ctrl", ctrl1, 8'h00);
    check("async reset ctrl nosat", ctrl0, 8'h00);
    check("async reset addr", {x1, y1}, 8'h00);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("after reset idle", ctrl1, 8'b1000_0000);
    @(negedge clock);
    check("no pending clear", ctrl1, 8'b1000_0000);

    // Back-to-back updates with three-cycle read latency.
    rst3_n = 1'b1;
    lat3_update(4'd1, 4'd2, 1'b0);
    lat3_update(4'd9, 4'd14, 1'b1);
    @(posedge clock); #1;
    upd_valid = 1'b0;
    @(negedge clock);
    check("lat3 idle after", ctrl3, 8'b1000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
